rmii_rx_framer: RTL and testbench

//  Receive-path stage directly downstream of the RMII pins (RMII_RX, CRS_DV) and upstream of the byte consumers (UART bridge, LED stats).

---
 rtl/rmii_rx_framer_pkg.sv | 16 +
 rtl/rmii_rx_framer_crc.sv | 35 +++
 rtl/rmii_rx_framer.sv | 207 ++++++++++++++++++++
 tb/tb_rmii_rx_framer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rmii_rx_framer_pkg.sv
// Shared definitions for the RMII receive framer: state encoding, preamble/SFD dibits and CRC-32 constants.
package rmii_pkg;

  typedef enum logic [1:0] {
    ST_DROP = 2'd0,
    ST_IDLE = 2'd1,
    ST_PRE  = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  localparam logic [1:0]  PRE_DIBIT      = 2'b01;
  localparam logic [1:0]  SFD_LAST_DIBIT = 2'b11;
  localparam logic [31:0] CRC_POLY       = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB20E3;

endpackage

// File: rtl/rmii_rx_framer_crc.sv
// crc32_d2: reflected CRC-32, two bits per clock (bit0 first), with synchronous init and enable.
module crc32_d2
  import rmii_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [1:0]  i_din,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;
  logic [31:0] w_crc;

  always_comb begin
    w_crc = r_crc;
    for (int i = 0; i < 2; i++) begin
      w_crc = {1'b0, w_crc[31:1]} ^ (((w_crc[0] ^ i_din[i]) == 1'b1) ? CRC_POLY : 32'h0);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_crc <= 32'hFFFF_FFFF;
    end else if (i_init) begin
      r_crc <= 32'hFFFF_FFFF;
    end else if (i_en) begin
      r_crc <= w_crc;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: preamble/SFD lock, dibit-to-byte assembly, SOF/EOF/ERR framing, good-frame counter.
// Optional CRC-32 check and CRC_OK output when RMII_RX_CRC_EN is defined.
module rmii_rx_framer
  import rmii_pkg::*;
#(
  parameter int unsigned MIN_PRE_DIBITS = 8,
  parameter int unsigned MIN_LEN        = 64,
  parameter int unsigned MAX_LEN        = 1522
) (
  input  logic        RMII_CLK,
  input  logic        RST,
  input  logic        RMII_CRS_DV,
  input  logic [1:0]  RMII_RX,
  output logic [7:0]  RX_DATA,
  output logic        RX_VALID,
  output logic        RX_SOF,
  output logic        RX_EOF,
  output logic        RX_ERR,
  output logic [15:0] FRAME_CNT
`ifdef RMII_RX_CRC_EN
  ,
  output logic        CRC_OK
`endif
);

  localparam int unsigned PRE_W  = $clog2(MIN_PRE_DIBITS) + 1;
  localparam int unsigned BCNT_W = 11;

  state_t              r_state, w_state;
  logic [PRE_W-1:0]    r_pre_cnt, w_pre_cnt;
  logic [1:0]          r_k, w_k;
  logic [5:0]          r_shift, w_shift;
  logic [7:0]          r_hold, w_hold;
  logic                r_hold_full, w_hold_full;
  logic                r_hold_sof, w_hold_sof;
  logic [BCNT_W-1:0]   r_byte_cnt, w_byte_cnt;
  logic [7:0]          r_data, w_data;
  logic                r_valid, w_valid;
  logic                r_sof, w_sof;
  logic                r_eof, w_eof;
  logic                r_err, w_err;
  logic [15:0]         r_frame_cnt, w_frame_cnt;
  logic [7:0]          w_byte;
  logic                w_crc_bad;

`ifdef RMII_RX_CRC_EN
  logic [31:0] w_crc;
  logic        w_crc_init;
  logic        w_crc_en;
  logic        r_crc_ok;

  assign w_crc_init = (r_state == ST_PRE) && (w_state == ST_DATA);
  assign w_crc_en   = (r_state == ST_DATA) && RMII_CRS_DV;

  crc32_d2 u_crc (
    .i_clk  (RMII_CLK),
    .i_rst  (RST),
    .i_init (w_crc_init),
    .i_en   (w_crc_en),
    .i_din  (RMII_RX),
    .o_crc  (w_crc)
  );

  assign w_crc_bad = (w_crc != CRC_RESIDUE);

  // CRC_OK is a level that only moves when a frame ends
  always_ff @(posedge RMII_CLK or posedge RST) begin
    if (RST) begin
      r_crc_ok <= 1'b0;
    end else if (w_valid && w_eof) begin
      r_crc_ok <= !w_crc_bad;
    end
  end

  assign CRC_OK = r_crc_ok;
`else
  assign w_crc_bad = 1'b0;
`endif

  assign w_byte = {RMII_RX, r_shift};

  always_comb begin
    w_state     = r_state;
    w_pre_cnt   = r_pre_cnt;
    w_k         = r_k;
    w_shift     = r_shift;
    w_hold      = r_hold;
    w_hold_full = r_hold_full;
    w_hold_sof  = r_hold_sof;
    w_byte_cnt  = r_byte_cnt;
    w_data      = r_data;
    w_valid     = 1'b0;
    w_sof       = 1'b0;
    w_eof       = 1'b0;
    w_err       = 1'b0;
    w_frame_cnt = r_frame_cnt;

    unique case (r_state)
      ST_DROP: begin
        if (!RMII_CRS_DV) w_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (RMII_CRS_DV && (RMII_RX == PRE_DIBIT)) begin
          w_state   = ST_PRE;
          w_pre_cnt = '0;
        end
      end
      ST_PRE: begin
        if (!RMII_CRS_DV) begin
          w_state = ST_IDLE;
        end else if (RMII_RX == PRE_DIBIT) begin
          if (r_pre_cnt != '1) w_pre_cnt = r_pre_cnt + PRE_W'(1);
        end else if ((RMII_RX == SFD_LAST_DIBIT) && (r_pre_cnt >= PRE_W'(MIN_PRE_DIBITS - 1))) begin
          w_state     = ST_DATA;
          w_k         = 2'd0;
          w_byte_cnt  = '0;
          w_hold_full = 1'b0;
        end else begin
          w_state = ST_DROP;
        end
      end
      ST_DATA: begin
        if (RMII_CRS_DV) begin
          w_k = r_k + 2'd1;
          unique case (r_k)
            2'd0:    w_shift[1:0] = RMII_RX;
            2'd1:    w_shift[3:2] = RMII_RX;
            2'd2:    w_shift[5:4] = RMII_RX;
            default: ;
          endcase
          if (r_k == 2'd3) begin
            w_data = r_hold;
            w_sof  = r_hold_sof;
            // byte MAX_LEN+1 just completed: flush the held byte as a failed end
            if (r_byte_cnt == BCNT_W'(MAX_LEN)) begin
              w_valid     = r_hold_full;
              w_eof       = 1'b1;
              w_err       = 1'b1;
              w_hold_full = 1'b0;
              w_state     = ST_DROP;
            end else begin
              w_valid     = r_hold_full;
              w_hold      = w_byte;
              w_hold_full = 1'b1;
              w_hold_sof  = (r_byte_cnt == '0);
              if (r_byte_cnt != '1) w_byte_cnt = r_byte_cnt + BCNT_W'(1);
            end
          end
        end else begin
          w_state = ST_IDLE;
          if (r_hold_full) begin
            w_valid     = 1'b1;
            w_data      = r_hold;
            w_sof       = r_hold_sof;
            w_eof       = 1'b1;
            w_err       = (r_k != 2'd0) || (r_byte_cnt < BCNT_W'(MIN_LEN)) || w_crc_bad;
            w_hold_full = 1'b0;
            if (!w_err) w_frame_cnt = r_frame_cnt + 16'd1;
          end
        end
      end
      default: w_state = ST_DROP;
    endcase
  end

  always_ff @(posedge RMII_CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_DROP;
      r_pre_cnt   <= '0;
      r_k         <= 2'd0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_hold_sof  <= 1'b0;
      r_byte_cnt  <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state;
      r_pre_cnt   <= w_pre_cnt;
      r_k         <= w_k;
      r_shift     <= w_shift;
      r_hold      <= w_hold;
      r_hold_full <= w_hold_full;
      r_hold_sof  <= w_hold_sof;
      r_byte_cnt  <= w_byte_cnt;
      r_data      <= w_data;
      r_valid     <= w_valid;
      r_sof       <= w_valid & w_sof;
      r_eof       <= w_valid & w_eof;
      r_err       <= w_valid & w_err;
      r_frame_cnt <= w_frame_cnt;
    end
  end

  assign RX_DATA   = r_data;
  assign RX_VALID  = r_valid;
  assign RX_SOF    = r_sof;
  assign RX_EOF    = r_eof;
  assign RX_ERR    = r_err;
  assign FRAME_CNT = r_frame_cnt;

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Bench for rmii_rx_framer: directed frame table, hand-written reset/abort sequences and random frames
// checked against a frame-level reference model. Follows RMII_RX_CRC_EN for the CRC_OK port.
module tb_rmii_rx_framer;

`ifdef RMII_RX_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif
  localparam int MAX_LEN = 1522;
  localparam int MIN_LEN = 64;
  localparam int GAP     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        crs;
  logic [1:0]  rx;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof, rx_err;
  logic [15:0] frame_cnt;
  logic        crc_ok_w;

  always #10 clk = ~clk;

  rmii_rx_framer dut (
    .RMII_CLK    (clk),
    .RST         (rst),
    .RMII_CRS_DV (crs),
    .RMII_RX     (rx),
    .RX_DATA     (rx_data),
    .RX_VALID    (rx_valid),
    .RX_SOF      (rx_sof),
    .RX_EOF      (rx_eof),
    .RX_ERR      (rx_err),
    .FRAME_CNT   (frame_cnt)
`ifdef RMII_RX_CRC_EN
    ,
    .CRC_OK      (crc_ok_w)
`endif
  );
`ifndef RMII_RX_CRC_EN
  assign crc_ok_w = 1'b0;
`endif

  typedef struct {
    logic [7:0]  data;
    logic        sof, eof, err;
    logic [15:0] fcnt;
    logic        crc_ok;
  } strobe_t;

  typedef struct {
    int n_pre; int len; int extra; bit flip;
    int exp_n; bit exp_err; bit exp_good; bit exp_crc;
  } vec_t;

  strobe_t    cap_q[$];
  logic [7:0] tx_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_fcnt = 0;

  always @(posedge clk) begin
    #1;
    if (rx_valid === 1'b1)
      cap_q.push_back('{data: rx_data, sof: rx_sof, eof: rx_eof, err: rx_err, fcnt: frame_cnt, crc_ok: crc_ok_w});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
    logic fb;
    fb = c[0] ^ b;
    c  = c >> 1;
    if (fb) c = c ^ 32'hEDB88320;
    return c;
  endfunction

  // Payload of len-4 bytes followed by its FCS (LSB first); frames shorter than 4 carry no FCS
  task automatic build_frame(input int len, input bit rnd);
    int          n;
    logic [31:0] c;
    logic [7:0]  b;
    tx_q.delete();
    n = (len >= 4) ? len - 4 : len;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom) : 8'(i);
      tx_q.push_back(b);
      for (int j = 0; j < 8; j++) c = crc_bit(c, b[j]);
    end
    if (len >= 4) begin
      c = ~c;
      for (int j = 0; j < 4; j++) tx_q.push_back(c[8*j +: 8]);
    end
  endtask

  // CRC residue the receiver holds at EOF: accepted bytes plus whatever trailing dibits were sampled
  function automatic bit model_crc_ok(input int len, input int extra, input logic [1:0] extra_rx);
    logic [31:0] c;
    logic [7:0]  b;
    int          nb;
    c  = 32'hFFFF_FFFF;
    nb = (len > MAX_LEN) ? MAX_LEN : len;
    for (int i = 0; i < nb; i++) begin
      b = tx_q[i];
      for (int j = 0; j < 8; j++) c = crc_bit(c, b[j]);
    end
    if (len > MAX_LEN) begin
      b = tx_q[MAX_LEN];
      for (int j = 0; j < 6; j++) c = crc_bit(c, b[j]);
    end else begin
      for (int e = 0; e < extra; e++) begin
        c = crc_bit(c, extra_rx[0]);
        c = crc_bit(c, extra_rx[1]);
      end
    end
    return c == 32'hDEBB20E3;
  endfunction

  task automatic dibit(input logic c, input logic [1:0] d);
    @(negedge clk);
    crs = c;
    rx  = d;
  endtask

  task automatic send_frame(input int n_pre, input int extra, input logic [1:0] extra_rx);
    logic [7:0] b;
    for (int i = 0; i < n_pre; i++) dibit(1'b1, 2'b01);
    dibit(1'b1, 2'b11);
    for (int i = 0; i < tx_q.size(); i++) begin
      b = tx_q[i];
      for (int k = 0; k < 4; k++) dibit(1'b1, b[2*k +: 2]);
    end
    for (int e = 0; e < extra; e++) dibit(1'b1, extra_rx);
    repeat (GAP) dibit(1'b0, 2'b00);
  endtask

  task automatic check_frame(input string tag, input int exp_n, input bit exp_err, input bit exp_good,
                             input bit exp_crc);
    int      bad_data;
    int      bad_frm;
    int      n;
    strobe_t s;
    bad_data = 0;
    bad_frm  = 0;
    if (exp_good) exp_fcnt++;
    chk({tag, "/strobes"}, 32'(cap_q.size()), 32'(exp_n));
    if (exp_n > 0 && cap_q.size() > 0) begin
      n = (cap_q.size() < exp_n) ? cap_q.size() : exp_n;
      for (int i = 0; i < n; i++) begin
        s = cap_q[i];
        if (s.data !== tx_q[i]) bad_data++;
        if (s.sof !== (i == 0)) bad_frm++;
        if (s.eof !== (i == exp_n - 1)) bad_frm++;
      end
      chk({tag, "/data_errs"}, 32'(bad_data), 32'd0);
      chk({tag, "/sof_eof_errs"}, 32'(bad_frm), 32'd0);
      s = cap_q[cap_q.size() - 1];
      chk({tag, "/err"}, 32'(s.err), 32'(exp_err));
      chk({tag, "/fcnt_at_eof"}, 32'(s.fcnt), 32'(16'(exp_fcnt)));
      if (CRC_EN) chk({tag, "/crc_ok"}, 32'(s.crc_ok), 32'(exp_crc));
    end
    chk({tag, "/fcnt"}, 32'(frame_cnt), 32'(16'(exp_fcnt)));
    cap_q.delete();
  endtask

  vec_t vt[11];

  initial begin
    vt[0]  = '{31,   64, 0, 0,   64, 0, 1, 1};
    vt[1]  = '{31,   64, 1, 0,   64, 1, 0, 0};
    vt[2]  = '{ 2,   64, 0, 0,    0, 0, 0, 0};
    vt[3]  = '{31, 1600, 0, 0, 1522, 1, 0, 0};
    vt[4]  = '{31,   64, 0, 0,   64, 0, 1, 1};
`ifdef RMII_RX_CRC_EN
    vt[5]  = '{31,   64, 0, 1,   64, 1, 0, 0};
`else
    vt[5]  = '{31,   64, 0, 1,   64, 0, 1, 0};
`endif
    vt[6]  = '{31,   63, 0, 0,   63, 1, 0, 1};
    vt[7]  = '{ 8,   64, 0, 0,   64, 0, 1, 1};
    vt[8]  = '{ 7,   64, 0, 0,    0, 0, 0, 0};
    vt[9]  = '{31, 1522, 0, 0, 1522, 0, 1, 1};
    vt[10] = '{31,    1, 0, 0,    1, 1, 0, 0};

    // Reset asserted with carrier up mid-frame
    rst = 1'b1;
    crs = 1'b1;
    rx  = 2'b01;
    repeat (3) @(negedge clk);
    chk("reset/valid", 32'(rx_valid), 32'd0);
    chk("reset/data",  32'(rx_data),  32'd0);
    chk("reset/flags", 32'({rx_sof, rx_eof, rx_err}), 32'd0);
    chk("reset/fcnt",  32'(frame_cnt), 32'd0);
    if (CRC_EN) chk("reset/crc_ok", 32'(crc_ok_w), 32'd0);
    rst = 1'b0;
    build_frame(64, 1'b0);
    send_frame(31, 0, 2'b00);
    check_frame("reset_midframe", 0, 0, 0, 0);

    for (int v = 0; v < 11; v++) begin
      build_frame(vt[v].len, 1'b0);
      if (vt[v].flip) tx_q[16] = tx_q[16] ^ 8'h01;
      send_frame(vt[v].n_pre, vt[v].extra, 2'b00);
      check_frame($sformatf("vec%0d", v), vt[v].exp_n, vt[v].exp_err, vt[v].exp_good, vt[v].exp_crc);
    end

    // Carrier lost during preamble, then a good frame straight after
    for (int i = 0; i < 5; i++) dibit(1'b1, 2'b01);
    dibit(1'b0, 2'b00);
    build_frame(64, 1'b1);
    send_frame(31, 0, 2'b00);
    check_frame("pre_abort", 64, 0, 1, 1);

    // Illegal preamble dibit drops the frame
    for (int i = 0; i < 10; i++) dibit(1'b1, 2'b01);
    dibit(1'b1, 2'b10);
    build_frame(64, 1'b1);
    send_frame(31, 0, 2'b00);
    check_frame("bad_pre", 0, 0, 0, 0);

    for (int r = 0; r < 25; r++) begin
      int         n_pre, len, extra, exp_n;
      bit         flip, ok, err, acc;
      logic [1:0] erx;
      n_pre = $urandom_range(31, 5);
      len   = ((r % 8) == 3) ? $urandom_range(1530, 1515) : $urandom_range(100, 1);
      extra = ($urandom_range(1, 0) == 1) ? 0 : $urandom_range(3, 1);
      erx   = 2'($urandom);
      flip  = ($urandom_range(3, 0) == 0);
      build_frame(len, 1'b1);
      if (flip) begin
        int idx;
        idx = $urandom_range(len - 1, 0);
        tx_q[idx] = tx_q[idx] ^ (8'h01 << $urandom_range(7, 0));
      end
      acc   = (n_pre >= 8);
      exp_n = acc ? ((len > MAX_LEN) ? MAX_LEN : len) : 0;
      ok    = model_crc_ok(len, extra, erx);
      err   = (extra != 0) || (len < MIN_LEN) || (len > MAX_LEN) || (CRC_EN && !ok);
      send_frame(n_pre, extra, erx);
      check_frame($sformatf("rand%0d", r), exp_n, err, acc && !err, ok);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
